// File: rtl/ibuf_rd_responder.sv
// Read responder for the input-buffer AR/R handshake: queues burst requests, reads the
// feature-map SRAM one word per credited cycle and returns the words as R beats with rlast.
module ibuf_rd_responder #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned MEM_AW   = 10,
  parameter int unsigned AQ_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AW-1:0]     araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  input  logic [3:0]        arburst_i,
  output logic [DW-1:0]     rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              rlast_o,
  output logic              mem_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic              err_burst_o
);

  localparam int unsigned AqPtrW = $clog2(AQ_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  // Request queue entries: start word address and beats-1.
  logic [MEM_AW-1:0] aq_addr_q [AQ_DEPTH];
  logic [7:0]        aq_len_q  [AQ_DEPTH];
  logic [AqPtrW-1:0] aq_wptr_q, aq_rptr_q;
  logic [AqPtrW:0]   aq_cnt_q, aq_cnt_d;
  logic              aq_full, aq_empty, aq_push, aq_pop;
  logic [3:0]        burst_clamped;
  logic [8:0]        push_beats;
  logic [7:0]        push_len;
  logic              err_burst_q;

  // Current burst being issued.
  logic [MEM_AW-1:0] base_q;
  logic [7:0]        len_q, idx_q;

  logic              issue, issue_last, credit;
  logic [MEM_AW-1:0] issue_addr;
  logic              rd_pend_q, rd_last_q;

  // Output buffer.
  logic [DW-1:0]     ob_data_q [2];
  logic              ob_last_q [2];
  logic              ob_wptr_q, ob_rptr_q;
  logic [1:0]        ob_cnt_q;
  logic              ob_rd;
  logic [2:0]        ob_level;

  if (AW > MEM_AW) begin : g_unused_addr
    logic unused_araddr;
    assign unused_araddr = ^araddr_i[AW-1:MEM_AW];
  end

  assign aq_full       = (aq_cnt_q == (AqPtrW + 1)'(AQ_DEPTH));
  assign aq_empty      = (aq_cnt_q == '0);
  assign arready_o     = !aq_full && rst_ni;
  assign aq_push       = arvalid_i && arready_o;
  assign burst_clamped = (arburst_i > 4'd8) ? 4'd8 : arburst_i;
  assign push_beats    = 9'd1 << burst_clamped;
  assign push_len      = 8'(push_beats - 9'd1);

  always_comb begin
    aq_cnt_d = aq_cnt_q;
    if (aq_push && !aq_pop) begin
      aq_cnt_d = aq_cnt_q + (AqPtrW + 1)'(1);
    end else if (!aq_push && aq_pop) begin
      aq_cnt_d = aq_cnt_q - (AqPtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aq_wptr_q   <= '0;
      aq_rptr_q   <= '0;
      aq_cnt_q    <= '0;
      err_burst_q <= 1'b0;
    end else begin
      aq_cnt_q <= aq_cnt_d;
      if (aq_push) begin
        aq_wptr_q <= aq_wptr_q + AqPtrW'(1);
        if (arburst_i > 4'd8) begin
          err_burst_q <= 1'b1;
        end
      end
      if (aq_pop) begin
        aq_rptr_q <= aq_rptr_q + AqPtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (aq_push) begin
      aq_addr_q[aq_wptr_q] <= araddr_i[MEM_AW-1:0];
      aq_len_q[aq_wptr_q]  <= push_len;
    end
  end

  assign err_burst_o = err_burst_q;

  // Issue only while the buffer plus in-flight reads, net of this cycle's pop, stays below 2.
  assign ob_rd    = rvalid_o && rready_i;
  assign ob_level = {1'b0, ob_cnt_q} + {2'b0, rd_pend_q};
  assign credit   = ob_level < (3'd2 + {2'b0, ob_rd});

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (aq_pop && !issue_last) state_d = StRun;
      StRun:  if (issue && issue_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = '0;
    aq_pop     = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        StIdle: begin
          if (!aq_empty && credit) begin
            issue      = 1'b1;
            aq_pop     = 1'b1;
            issue_addr = aq_addr_q[aq_rptr_q];
            issue_last = (aq_len_q[aq_rptr_q] == 8'd0);
          end
        end
        StRun: begin
          if (credit) begin
            issue      = 1'b1;
            issue_addr = base_q + MEM_AW'(idx_q);
            issue_last = (idx_q == len_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en_o   = issue;
  assign mem_addr_o = issue_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      rd_last_q <= issue_last;
      if (aq_pop) begin
        base_q <= aq_addr_q[aq_rptr_q];
        len_q  <= aq_len_q[aq_rptr_q];
        idx_q  <= 8'd1;
      end else if (issue) begin
        idx_q <= idx_q + 8'd1;
      end
    end
  end

  // SRAM data lands in the buffer one cycle after its read was issued.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ob_wptr_q <= 1'b0;
      ob_rptr_q <= 1'b0;
      ob_cnt_q  <= 2'd0;
    end else begin
      if (rd_pend_q) begin
        ob_wptr_q <= !ob_wptr_q;
      end
      if (ob_rd) begin
        ob_rptr_q <= !ob_rptr_q;
      end
      if (rd_pend_q && !ob_rd) begin
        ob_cnt_q <= ob_cnt_q + 2'd1;
      end else if (!rd_pend_q && ob_rd) begin
        ob_cnt_q <= ob_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_pend_q) begin
      ob_data_q[ob_wptr_q] <= mem_rdata_i;
      ob_last_q[ob_wptr_q] <= rd_last_q;
    end
  end

  assign rvalid_o = (ob_cnt_q != 2'd0);
  assign rdata_o  = rvalid_o ? ob_data_q[ob_rptr_q] : '0;
  assign rlast_o  = rvalid_o && ob_last_q[ob_rptr_q];

endmodule

// File: tb/tb_ibuf_rd_responder.sv
// Bench for ibuf_rd_responder: SRAM model with mem[i]=i, a queue-based beat model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ibuf_rd_responder;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MEM_AW = 10;
  localparam int unsigned AQ_DEPTH = 2;

  logic              clk, rst_n;
  logic [AW-1:0]     araddr;
  logic              arvalid, arready;
  logic [3:0]        arburst;
  logic [DW-1:0]     rdata;
  logic              rvalid, rready, rlast;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic              err_burst;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  bit            err_m, prev_hold, prev_last;
  logic [DW-1:0] prev_data;
  int            issued, consumed;
  int            n_cmp, n_err;
  int            rmode, pat_idx;

  ibuf_rd_responder #(
    .DW(DW), .AW(AW), .MEM_AW(MEM_AW), .AQ_DEPTH(AQ_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .araddr_i(araddr), .arvalid_i(arvalid),
    .arready_o(arready), .arburst_i(arburst), .rdata_o(rdata), .rvalid_o(rvalid),
    .rready_i(rready), .rlast_o(rlast), .mem_en_o(mem_en), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .err_burst_o(err_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
  end

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // Reference model: every accepted request expands into its beats in order.
  always @(negedge clk) begin
    int beats;
    logic [3:0] bc;
    if (!rst_n) begin
      check("rst_arready", 64'(arready), 64'(0));
      check("rst_mem_en", 64'(mem_en), 64'(0));
      exp_data.delete();
      exp_last.delete();
      err_m = 1'b0;
      issued = 0;
      consumed = 0;
      prev_hold = 1'b0;
    end else begin
      check("err_burst", 64'(err_burst), 64'(err_m));
      if (prev_hold) begin
        check("hold_valid", 64'(rvalid), 64'(1));
        check("hold_data", 64'(rdata), 64'(prev_data));
        check("hold_last", 64'(rlast), 64'(prev_last));
      end
      if (mem_en) issued++;
      if (rvalid && rready) begin
        consumed++;
        if (exp_data.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got rdata 0x%0h, expected no beat", rdata);
        end else begin
          check("rdata", 64'(rdata), 64'(exp_data.pop_front()));
          check("rlast", 64'(rlast), 64'(exp_last.pop_front()));
        end
      end
      if (mem_en) check("outstanding_le2", 64'(issued - consumed > 2), 64'(0));
      if (arvalid && arready) begin
        bc = (arburst > 4'd8) ? 4'd8 : arburst;
        beats = 1 << bc;
        for (int k = 0; k < beats; k++) begin
          exp_data.push_back(mem[(int'(araddr[9:0]) + k) % 1024]);
          exp_last.push_back(k == beats - 1);
        end
        if (arburst > 4'd8) err_m = 1'b1;
      end
      prev_hold = rvalid && !rready;
      prev_data = rdata;
      prev_last = rlast;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 1) begin
      rready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
      pat_idx++;
    end else if (rmode == 2) begin
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic do_req(input logic [31:0] a, input logic [3:0] b);
    int t;
    t = 0;
    araddr = a;
    arburst = b;
    arvalid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!arready && t < 2000);
    if (!arready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: got arready 0, expected 1 within 2000 cycles");
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int idle, t;
    idle = 0;
    t = 0;
    while (idle < 4 && t < 5000) begin
      @(negedge clk);
      t++;
      if (!rvalid && !mem_en) idle++;
      else idle = 0;
    end
    if (idle < 4) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got busy output, expected idle within 5000 cycles");
    end
    @(posedge clk);
    #2;
    check("drain_model_empty", 64'(exp_data.size()), 64'(0));
  endtask

  initial begin
    #600000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got no completion, expected finish before 600000 ns");
    summary();
    $finish;
  end

  initial begin
    int k, t, n;
    bit seen_last;
    logic [MEM_AW-1:0] got [8];
    logic [MEM_AW-1:0] wrap_exp [4];
    logic [3:0] b;
    int r;
    n_cmp = 0;
    n_err = 0;
    rmode = 0;
    pat_idx = 0;
    rst_n = 1'b0;
    arvalid = 1'b0;
    araddr = '0;
    arburst = '0;
    rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rvalid", 64'(rvalid), 64'(0));
    check("reset_rlast", 64'(rlast), 64'(0));
    check("reset_rdata", 64'(rdata), 64'(0));
    check("reset_mem_addr", 64'(mem_addr), 64'(0));
    check("reset_err", 64'(err_burst), 64'(0));
    step();
    rst_n = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    check("arready_after_rst", 64'(arready), 64'(1));

    // Single 4-beat burst: first beat three cycles after the handshake.
    step();
    do_req(32'h10, 4'd2);
    @(negedge clk);
    check("t1_mem_en", 64'(mem_en), 64'(1));
    check("t1_mem_addr", 64'(mem_addr), 64'h10);
    check("t1_rvalid_t1", 64'(rvalid), 64'(0));
    @(negedge clk);
    check("t1_rvalid_t2", 64'(rvalid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_rvalid", 64'(rvalid), 64'(1));
      check("t1_rdata", 64'(rdata), 64'(32'h10 + i));
      check("t1_rlast", 64'(rlast), 64'(i == 3));
    end
    drain();

    // Back-to-back bursts with no bubble.
    do_req(32'h0, 4'd3);
    do_req(32'h40, 4'd0);
    @(negedge clk);
    check("b2b_rvalid_t2", 64'(rvalid), 64'(0));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("b2b_rvalid", 64'(rvalid), 64'(1));
      check("b2b_arready", 64'(arready), 64'(1));
      check("b2b_rdata", 64'(rdata), (i < 8) ? 64'(i) : 64'h40);
      check("b2b_rlast", 64'(rlast), 64'(i == 7 || i == 8));
    end
    @(negedge clk);
    check("b2b_rvalid_after", 64'(rvalid), 64'(0));
    drain();

    // rready pattern 1,0,0,1: in-order single delivery, hold checked by the model.
    pat_idx = 0;
    rmode = 1;
    do_req(32'h100, 4'd3);
    k = 0;
    t = 0;
    while (k < 8 && t < 200) begin
      @(negedge clk);
      t++;
      if (rvalid && rready) begin
        check("stall_rdata", 64'(rdata), 64'(32'h100 + k));
        k++;
      end
    end
    check("stall_beats", 64'(k), 64'(8));
    step();
    rmode = 0;
    rready = 1'b1;
    drain();

    // Address wrap-around at the top of the SRAM.
    wrap_exp[0] = 10'h3FE;
    wrap_exp[1] = 10'h3FF;
    wrap_exp[2] = 10'h000;
    wrap_exp[3] = 10'h001;
    do_req(32'h3FE, 4'd2);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_en && n < 8) begin
        got[n] = mem_addr;
        n++;
      end
    end
    check("wrap_issue_count", 64'(n), 64'(4));
    for (int i = 0; i < 4; i++) check("wrap_mem_addr", 64'(got[i]), 64'(wrap_exp[i]));
    drain();

    // Oversized burst code clamps to 256 beats and sets the sticky error.
    do_req(32'h300, 4'hA);
    n = 0;
    t = 0;
    seen_last = 1'b0;
    while (!seen_last && t < 1000) begin
      @(negedge clk);
      t++;
      if (rvalid && rready) begin
        n++;
        if (rlast) seen_last = 1'b1;
      end
    end
    check("clamp_beats", 64'(n), 64'(256));
    check("err_set", 64'(err_burst), 64'(1));
    drain();
    do_req(32'h5, 4'd1);
    drain();
    check("err_sticky", 64'(err_burst), 64'(1));

    // Reset in the middle of a 16-beat burst.
    do_req(32'h200, 4'd4);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(rvalid && rdata == 32'h203) && t < 50);
    check("mid_reached_beat3", 64'(rdata), 64'h203);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rvalid", 64'(rvalid), 64'(0));
    check("mid_arready", 64'(arready), 64'(1));
    check("mid_mem_en", 64'(mem_en), 64'(0));
    check("mid_err_cleared", 64'(err_burst), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_replay", 64'(rvalid), 64'(0));
    end
    step();
    do_req(32'h20, 4'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_rdata", 64'(rdata), 64'(32'h20 + i));
      check("post_rst_rlast", 64'(rlast), 64'(i == 1));
    end
    drain();

    // Randomized requests and backpressure.
    rmode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) step();
      r = $urandom_range(0, 15);
      if (r < 12) b = 4'(r % 5);
      else if (r < 14) b = 4'($urandom_range(5, 8));
      else b = 4'($urandom_range(9, 15));
      do_req($urandom, b);
    end
    step();
    rmode = 0;
    rready = 1'b1;
    drain();

    summary();
    $finish;
  end

endmodule
